// File: rtl/player_timer_pkg.sv
// Shared types, constants and BCD helpers for the chess-clock player timer.
//   state_e   : timer FSM state codes
//   step_op_e : operation selector for the MM:SS step datapath
//   mmss_t    : packed MM:SS payload (BCD minutes, BCD seconds)
package player_timer_pkg;

  localparam int unsigned BCD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  typedef enum logic {
    OP_DEC = 1'b0,
    OP_ADD = 1'b1
  } step_op_e;

  typedef struct packed {
    logic [BCD_W-1:0] min;
    logic [BCD_W-1:0] sec;
  } mmss_t;

  localparam logic [BCD_W-1:0] BCD_00 = 8'h00;
  localparam logic [BCD_W-1:0] BCD_59 = 8'h59;
  localparam logic [BCD_W-1:0] BCD_99 = 8'h99;

  // Both nibbles must be decimal digits.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Two-digit BCD to binary (0..99).
  function automatic logic [6:0] bcd2bin(input logic [BCD_W-1:0] v);
    return (7'(v[7:4]) * 7'd10) + 7'(v[3:0]);
  endfunction

  // Binary (0..99) to two-digit BCD.
  function automatic logic [BCD_W-1:0] bin2bcd(input logic [6:0] v);
    logic [6:0] tens;
    tens = v / 7'd10;
    return {4'(tens), 4'(v - (tens * 7'd10))};
  endfunction

  // Two-digit BCD decrement with borrow; caller guarantees v != 00.
  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/player_timer_bcd_mmss_step.sv
// Combinational MM:SS step: one-second decrement or add-bonus-seconds.
//   min, sec  : current BCD count
//   op        : OP_DEC or OP_ADD
//   inc       : BCD seconds to add in OP_ADD (00..59)
//   min_nxt,
//   sec_nxt   : stepped count (minutes unchanged when saturating)
//   zero      : stepped count is 00:00
//   sat       : add carried out of 99 minutes; caller clamps to 99:59
module player_timer_bcd_mmss_step
  import player_timer_pkg::*;
(
  input  logic       min_dummy_unused_guard_n,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic       op,
  input  logic [7:0] inc,
  output logic [7:0] min_nxt,
  output logic [7:0] sec_nxt,
  output logic       zero,
  output logic       sat
);

  logic [6:0] sum;
  logic       carry;

  // Dec borrows from minutes at :00; add carries into minutes past :59.
  always_comb begin
    min_nxt = min;
    sec_nxt = sec;
    sat     = 1'b0;
    sum     = 7'd0;
    carry   = 1'b0;
    if (op == OP_ADD) begin
      sum   = bcd2bin(sec) + bcd2bin(inc);
      carry = (sum >= 7'd60);
      if (carry) sum = sum - 7'd60;
      sec_nxt = bin2bcd(sum);
      if (carry) begin
        if (min == BCD_99) sat = 1'b1;
        else               min_nxt = bin2bcd(bcd2bin(min) + 7'd1);
      end
    end else if (sec == BCD_00) begin
      sec_nxt = BCD_59;
      min_nxt = bcd_dec(min);
    end else begin
      sec_nxt = bcd_dec(sec);
    end
    zero = (min_nxt == BCD_00) && (sec_nxt == BCD_00) && min_dummy_unused_guard_n;
  end

endmodule

// File: rtl/player_timer.sv
// Per-player chess-clock countdown in BCD MM:SS with Fischer bonus.
//   CLK        : system clock, rising edge
//   CLR        : synchronous active-high reset, highest priority
//   CE         : 1 Hz tick strobe, one CLK wide
//   ENABLE     : high while it is this player's turn
//   LOAD       : pulse, load PRESET_MIN:00 and rearm
//   PRESET_MIN : BCD minutes; invalid digits fall back to DEFAULT_MIN
//   MIN, SEC   : BCD time remaining
//   END        : sticky flag-fall
//   LOW_TIME   : under LOW_SEC seconds left and not expired
//   RUNNING    : timer is in RUN
module player_timer
  import player_timer_pkg::*;
#(
  parameter logic [7:0] DEFAULT_MIN = 8'h05,
  parameter logic [7:0] INC_SEC     = 8'h00,
  parameter logic [7:0] LOW_SEC     = 8'h10
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       ENABLE,
  input  logic       LOAD,
  input  logic [7:0] PRESET_MIN,
  output logic [7:0] MIN,
  output logic [7:0] SEC,
  output logic       END,
  output logic       LOW_TIME,
  output logic       RUNNING
);

  state_e     state_q, state_nxt;
  mmss_t      cnt_q, cnt_nxt;
  logic       end_q, end_nxt;
  logic       enable_d;

  step_op_e   step_op;
  logic [7:0] step_min, step_sec;
  logic       step_zero, step_sat;
  logic [7:0] load_min;
  logic       tick, handover;

  assign tick     = CE && ENABLE;
  assign handover = enable_d && !ENABLE;
  assign step_op  = tick ? OP_DEC : OP_ADD;
  assign load_min = bcd_valid(PRESET_MIN) ? PRESET_MIN : DEFAULT_MIN;

  player_timer_bcd_mmss_step u_step (
    .min_dummy_unused_guard_n (1'b1),
    .min                      (cnt_q.min),
    .sec                      (cnt_q.sec),
    .op                       (step_op),
    .inc                      (INC_SEC),
    .min_nxt                  (step_min),
    .sec_nxt                  (step_sec),
    .zero                     (step_zero),
    .sat                      (step_sat)
  );

  // State and count registers.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '{min: DEFAULT_MIN, sec: BCD_00};
      end_q    <= 1'b0;
      enable_d <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      end_q    <= end_nxt;
      enable_d <= ENABLE;
    end
  end

  // Priority mux: LOAD > expired hold > tick/expiry > handover bonus > state update.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    end_nxt   = end_q;
    if (LOAD) begin
      cnt_nxt = '{min: load_min, sec: BCD_00};
      if (load_min == BCD_00) begin
        end_nxt   = 1'b1;
        state_nxt = ST_EXPIRED;
      end else begin
        end_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    end else if (state_q == ST_EXPIRED) begin
      // Frozen at 00:00 with END held until CLR or LOAD.
    end else if (tick) begin
      cnt_nxt = '{min: step_min, sec: step_sec};
      if (step_zero) begin
        end_nxt   = 1'b1;
        state_nxt = ST_EXPIRED;
      end else begin
        state_nxt = ST_RUN;
      end
    end else if (handover) begin
      cnt_nxt   = step_sat ? '{min: BCD_99, sec: BCD_59}
                           : '{min: step_min, sec: step_sec};
      state_nxt = ST_PAUSE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: if (ENABLE)  state_nxt = ST_RUN;
        ST_RUN:            if (!ENABLE) state_nxt = ST_PAUSE;
        default:           ;
      endcase
    end
  end

  assign MIN      = cnt_q.min;
  assign SEC      = cnt_q.sec;
  assign END      = end_q;
  assign LOW_TIME = (cnt_q.min == BCD_00) && (cnt_q.sec < LOW_SEC) && !end_q;
  assign RUNNING  = (state_q == ST_RUN);

endmodule

// File: tb/tb_player_timer.sv
module tb_player_timer;

  localparam int MAX_SECS = 99 * 60 + 59;
  localparam int DEF_SECS = 5 * 60;
  localparam int INC      = 5;
  localparam int LOW      = 10;

  logic       clk = 1'b0;
  logic       clr = 1'b0, ce = 1'b0, enable = 1'b0, load = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] min_o, sec_o;
  logic       end_o, low_time, running;

  int errors = 0;
  int checks = 0;

  // Reference: remaining time as plain seconds plus expired/running flags.
  int m_t    = 0;
  bit m_exp  = 1'b0;
  bit m_run  = 1'b0;
  bit m_en_d = 1'b0;

  always #5 clk = ~clk;

  player_timer #(
    .DEFAULT_MIN (8'h05),
    .INC_SEC     (8'h05),
    .LOW_SEC     (8'h10)
  ) dut (
    .CLK        (clk),
    .CLR        (clr),
    .CE         (ce),
    .ENABLE     (enable),
    .LOAD       (load),
    .PRESET_MIN (preset_min),
    .MIN        (min_o),
    .SEC        (sec_o),
    .END        (end_o),
    .LOW_TIME   (low_time),
    .RUNNING    (running)
  );

  function automatic logic [7:0] to_bcd(input int x);
    logic [7:0] r;
    r[7:4] = 4'(x / 10);
    r[3:0] = 4'(x % 10);
    return r;
  endfunction

  function automatic void model_edge(input bit c, input bit l, input logic [7:0] p,
                                     input bit t, input bit e);
    if (c) begin
      m_t = DEF_SECS; m_exp = 0; m_run = 0;
    end else if (l) begin
      if (p[7:4] <= 4'd9 && p[3:0] <= 4'd9) m_t = (int'(p[7:4]) * 10 + int'(p[3:0])) * 60;
      else m_t = DEF_SECS;
      m_exp = (m_t == 0);
      m_run = 0;
    end else if (m_exp) begin
      m_run = 0;
    end else if (t && e) begin
      m_t = m_t - 1;
      m_exp = (m_t == 0);
      m_run = !m_exp;
    end else if (m_en_d && !e) begin
      m_t = (m_t + INC > MAX_SECS) ? MAX_SECS : m_t + INC;
      m_run = 0;
    end else begin
      m_run = e;
    end
    m_en_d = c ? 1'b0 : e;
  endfunction

  function automatic logic [18:0] model_vec();
    int mm, ss;
    bit lo;
    mm = m_t / 60;
    ss = m_t % 60;
    lo = (mm == 0) && (ss < LOW) && !m_exp;
    return {to_bcd(mm), to_bcd(ss), m_exp, lo, m_run};
  endfunction

  task automatic cyc(input bit c, input bit l, input logic [7:0] p, input bit t, input bit e);
    clr = c; load = l; preset_min = p; ce = t; enable = e;
    @(posedge clk);
    model_edge(c, l, p, t, e);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 8'h00, 0, 0);
    checks++;
    if ({min_o, sec_o} !== 16'h0500) begin
      errors++; $display("FAIL reset_mmss: got %h:%h want 05:00", min_o, sec_o);
    end
    checks++;
    if ({end_o, low_time, running} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got end/low/run=%b want 000", {end_o, low_time, running});
    end
    cyc(0, 0, 8'h00, 1, 1);
    checks++;
    if ({min_o, sec_o, running} !== {16'h0459, 1'b1}) begin
      errors++; $display("FAIL first_tick: got %h:%h run=%b want 04:59 run=1", min_o, sec_o, running);
    end
  endtask

  task automatic test_expiry();
    cyc(0, 1, 8'h01, 0, 1);
    for (int i = 1; i <= 60; i++) begin
      cyc(0, 0, 8'h00, 1, 1);
      checks++;
      if ({min_o, sec_o, end_o, low_time, running} !== model_vec()) begin
        errors++; $display("FAIL expiry_count ce=%0d: got %h want %h", i,
                           {min_o, sec_o, end_o, low_time, running}, model_vec());
      end
      if (i == 59) begin
        checks++;
        if ({min_o, sec_o, end_o} !== {16'h0001, 1'b0}) begin
          errors++; $display("FAIL expiry_59: got %h:%h end=%b want 00:01 end=0", min_o, sec_o, end_o);
        end
      end
    end
    checks++;
    if ({min_o, sec_o, end_o, running} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL expiry_60: got %h:%h end=%b run=%b want 00:00 end=1 run=0",
                         min_o, sec_o, end_o, running);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 8'h00, 1, bit'(i % 2));
      checks++;
      if ({min_o, sec_o, end_o, low_time} !== {16'h0000, 2'b10}) begin
        errors++; $display("FAIL expired_hold %0d: got %h:%h end=%b low=%b want 00:00 end=1 low=0",
                           i, min_o, sec_o, end_o, low_time);
      end
    end
  endtask

  task automatic test_bonus_handover();
    cyc(0, 1, 8'h03, 0, 0);
    cyc(0, 0, 8'h00, 0, 1);
    checks++;
    if ({min_o, sec_o, running} !== {16'h0300, 1'b1}) begin
      errors++; $display("FAIL idle_enable_no_ce: got %h:%h run=%b want 03:00 run=1", min_o, sec_o, running);
    end
    repeat (3) cyc(0, 0, 8'h00, 1, 1);
    checks++;
    if ({min_o, sec_o} !== 16'h0257) begin
      errors++; $display("FAIL pre_handover: got %h:%h want 02:57", min_o, sec_o);
    end
    cyc(0, 0, 8'h00, 1, 0);
    checks++;
    if ({min_o, sec_o, running} !== {16'h0302, 1'b0}) begin
      errors++; $display("FAIL handover_bonus: got %h:%h run=%b want 03:02 run=0", min_o, sec_o, running);
    end
    cyc(0, 0, 8'h00, 1, 0);
    checks++;
    if ({min_o, sec_o} !== 16'h0302) begin
      errors++; $display("FAIL paused_hold: got %h:%h want 03:02", min_o, sec_o);
    end
  endtask

  task automatic test_saturate();
    cyc(0, 1, 8'h99, 0, 0);
    repeat (11) begin
      cyc(0, 0, 8'h00, 0, 1);
      cyc(0, 0, 8'h00, 0, 0);
    end
    checks++;
    if ({min_o, sec_o} !== 16'h9955) begin
      errors++; $display("FAIL bonus_accum: got %h:%h want 99:55", min_o, sec_o);
    end
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 0);
    checks++;
    if ({min_o, sec_o} !== 16'h9959) begin
      errors++; $display("FAIL sat_carry: got %h:%h want 99:59", min_o, sec_o);
    end
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 0, 0);
    checks++;
    if ({min_o, sec_o} !== 16'h9959) begin
      errors++; $display("FAIL sat_9958: got %h:%h want 99:59", min_o, sec_o);
    end
    cyc(0, 1, 8'h1A, 0, 0);
    checks++;
    if ({min_o, sec_o, end_o} !== {16'h0500, 1'b0}) begin
      errors++; $display("FAIL load_bad_lo: got %h:%h end=%b want 05:00 end=0", min_o, sec_o, end_o);
    end
    cyc(0, 1, 8'hA3, 0, 0);
    checks++;
    if ({min_o, sec_o} !== 16'h0500) begin
      errors++; $display("FAIL load_bad_hi: got %h:%h want 05:00", min_o, sec_o);
    end
  endtask

  task automatic test_load_priority();
    cyc(0, 1, 8'h20, 0, 1);
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 1, 8'h12, 1, 1);
    checks++;
    if ({min_o, sec_o, end_o, running} !== {16'h1200, 2'b00}) begin
      errors++; $display("FAIL load_over_ce: got %h:%h end=%b run=%b want 12:00 end=0 run=0",
                         min_o, sec_o, end_o, running);
    end
    cyc(0, 1, 8'h00, 1, 1);
    checks++;
    if ({min_o, sec_o, end_o, low_time, running} !== {16'h0000, 3'b100}) begin
      errors++; $display("FAIL load_zero: got %h:%h end=%b low=%b run=%b want 00:00 end=1 low=0 run=0",
                         min_o, sec_o, end_o, low_time, running);
    end
    cyc(0, 0, 8'h00, 1, 0);
    checks++;
    if ({min_o, sec_o, end_o} !== {16'h0000, 1'b1}) begin
      errors++; $display("FAIL load_zero_hold: got %h:%h end=%b want 00:00 end=1", min_o, sec_o, end_o);
    end
    cyc(0, 1, 8'h07, 0, 0);
    checks++;
    if ({min_o, sec_o, end_o} !== {16'h0700, 1'b0}) begin
      errors++; $display("FAIL rearm: got %h:%h end=%b want 07:00 end=0", min_o, sec_o, end_o);
    end
  endtask

  task automatic test_low_time();
    cyc(0, 1, 8'h01, 0, 1);
    repeat (49) cyc(0, 0, 8'h00, 1, 1);
    checks++;
    if ({min_o, sec_o, low_time} !== {16'h0011, 1'b0}) begin
      errors++; $display("FAIL low_0011: got %h:%h low=%b want 00:11 low=0", min_o, sec_o, low_time);
    end
    cyc(0, 0, 8'h00, 1, 1);
    checks++;
    if ({min_o, sec_o, low_time} !== {16'h0010, 1'b0}) begin
      errors++; $display("FAIL low_0010: got %h:%h low=%b want 00:10 low=0", min_o, sec_o, low_time);
    end
    cyc(0, 0, 8'h00, 1, 1);
    checks++;
    if ({min_o, sec_o, low_time} !== {16'h0009, 1'b1}) begin
      errors++; $display("FAIL low_0009: got %h:%h low=%b want 00:09 low=1", min_o, sec_o, low_time);
    end
    cyc(1, 0, 8'h00, 1, 1);
    checks++;
    if ({min_o, sec_o, end_o, low_time, running} !== {16'h0500, 3'b000}) begin
      errors++; $display("FAIL mid_clr: got %h:%h flags=%b want 05:00 flags=000",
                         min_o, sec_o, {end_o, low_time, running});
    end
  endtask

  task automatic test_random();
    bit         c, l, t, e;
    logic [7:0] p;
    e = 1'b0;
    for (int i = 0; i < 800; i++) begin
      c = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) e = !e;
      if ($urandom_range(0, 3) == 0) p = 8'($urandom);
      else                           p = to_bcd($urandom_range(0, 2));
      cyc(c, l, p, t, e);
      checks++;
      if ({min_o, sec_o, end_o, low_time, running} !== model_vec()) begin
        errors++; $display("FAIL random cyc=%0d: got %h want %h", i,
                           {min_o, sec_o, end_o, low_time, running}, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_bonus_handover();
    test_saturate();
    test_load_priority();
    test_low_time();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
